// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle chunked adder/subtractor with carry-out and signed overflow
//
// Parameters:
//   WIDTH    operand/result width, a multiple of CHUNK
//   CHUNK    bits added per clock, 1..WIDTH
// Ports:
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low reset
//   start    request, sampled only while idle
//   a, b     operands, captured on the accepted start edge
//   cin      carry-in for add, ignored for subtract
//   sub      0: a+b+cin, 1: a-b (a+~b+1)
//   result   sum/difference, updated on completion only
//   cout     carry out of the MSB (subtract: 1 = no borrow)
//   overflow signed overflow of the completed operation
//   busy     high while chunks are being processed
//   done     one-cycle completion pulse
module chunked_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;     // already inverted for subtract
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    int               idx;
    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK:0]   sum;
    logic             ov_last;

    assign busy = (state == RUN);
    assign last = (cnt == CW'(N - 1));

    // One CHUNK-bit ripple per cycle on the slice selected by the counter.
    always_comb begin
        idx      = int'(cnt) * CHUNK;
        a_s      = op_a[idx +: CHUNK];
        b_s      = op_b[idx +: CHUNK];
        sum      = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, carry};
        acc_next = acc;
        acc_next[idx +: CHUNK] = sum[CHUNK-1:0];
        // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
        ov_last  = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= sum[CHUNK];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        result   <= acc_next;
                        cout     <= sum[CHUNK];
                        overflow <= ov_last;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_add_sub.sv
// tb/tb_chunked_add_sub.sv - directed self-checking bench for chunked_add_sub
module tb_chunked_add_sub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;

    logic [31:0] r8, r32, r1;
    logic        c8, c32, c1;
    logic        o8, o32, o1;
    logic        busy8, busy32, busy1;
    logic        done8, done32, done1;

    int n_checks = 0;
    int n_fail   = 0;

    chunked_add_sub #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .result(r8), .cout(c8), .overflow(o8), .busy(busy8), .done(done8)
    );

    chunked_add_sub #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .result(r32), .cout(c32), .overflow(o32), .busy(busy32), .done(done32)
    );

    chunked_add_sub #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .result(r1), .cout(c1), .overflow(o1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one accepted edge and returns edges until done8.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tcin, input logic tsub, output int lat);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        tick;
        start = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 60) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0;
        tick;
        tick;
        n_checks++; if (r8 !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 00000000", r8); end
        n_checks++; if (c8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b exp 0", c8); end
        n_checks++; if (o8 !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", o8); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy8); end
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done8); end
        rst_n = 1'b1;
        tick;
        n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL reset_release_busy got %b exp 1", busy8); end
        start = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_add_ripple;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                n_fail++; $display("FAIL ripple_busy cycle %0d got busy=%b done=%b exp busy=1 done=0", i, busy8, done8);
            end
            tick;
        end
        n_checks++; if (done8 !== 1'b1) begin n_fail++; $display("FAIL ripple_done got %b exp 1", done8); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL ripple_busy_end got %b exp 0", busy8); end
        n_checks++; if (r8 !== 32'h0) begin n_fail++; $display("FAIL ripple_result got %h exp 00000000", r8); end
        n_checks++; if (c8 !== 1'b1) begin n_fail++; $display("FAIL ripple_cout got %b exp 1", c8); end
        n_checks++; if (o8 !== 1'b0) begin n_fail++; $display("FAIL ripple_overflow got %b exp 0", o8); end
        tick;
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL ripple_done_fall got %b exp 0", done8); end
    endtask

    task automatic test_subtract;
        int lat;
        run_op(32'd5, 32'd7, 1'b1, 1'b1, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL sub_latency got %0d exp 4", lat); end
        n_checks++; if (r8 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_result got %h exp fffffffe", r8); end
        n_checks++; if (c8 !== 1'b0) begin n_fail++; $display("FAIL sub_cout got %b exp 0", c8); end
        n_checks++; if (o8 !== 1'b0) begin n_fail++; $display("FAIL sub_overflow got %b exp 0", o8); end
    endtask

    task automatic test_overflow;
        int lat;
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        n_checks++; if (r8 !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_add_result got %h exp 80000000", r8); end
        n_checks++; if (o8 !== 1'b1) begin n_fail++; $display("FAIL ovf_add_overflow got %b exp 1", o8); end
        n_checks++; if (c8 !== 1'b0) begin n_fail++; $display("FAIL ovf_add_cout got %b exp 0", c8); end
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat);
        n_checks++; if (r8 !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL ovf_sub_result got %h exp 7fffffff", r8); end
        n_checks++; if (o8 !== 1'b1) begin n_fail++; $display("FAIL ovf_sub_overflow got %b exp 1", o8); end
        n_checks++; if (c8 !== 1'b1) begin n_fail++; $display("FAIL ovf_sub_cout got %b exp 1", c8); end
    endtask

    task automatic test_back_to_back;
        int lat;
        a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick;
        a = 32'd10; b = 32'd20;
        lat = 0;
        while (done8 !== 1'b1 && lat < 60) begin
            tick;
            lat++;
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL held_start_latency got %0d exp 4", lat); end
        n_checks++; if (r8 !== 32'd3) begin n_fail++; $display("FAIL held_start_result got %0d exp 3", r8); end
        tick;
        n_checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", busy8, done8);
        end
        n_checks++; if (r8 !== 32'd3) begin n_fail++; $display("FAIL b2b_hold_result got %0d exp 3", r8); end
        start = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 60) begin
            tick;
            lat++;
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_latency got %0d exp 4", lat); end
        n_checks++; if (r8 !== 32'd30) begin n_fail++; $display("FAIL b2b_result got %0d exp 30", r8); end
    endtask

    task automatic test_reset_mid_run;
        int dones;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy8); end
        n_checks++; if (r8 !== 32'h0) begin n_fail++; $display("FAIL abort_result got %h exp 00000000", r8); end
        n_checks++; if (c8 !== 1'b0 || o8 !== 1'b0) begin n_fail++; $display("FAIL abort_flags got cout=%b ovf=%b exp 0 0", c8, o8); end
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done8 === 1'b1) dones++;
            tick;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses exp 0", dones); end
    endtask

    task automatic test_param_sweep;
        int l8, l32, l1;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        l8 = 0; l32 = 0; l1 = 0;
        if (done32 === 1'b1) l32 = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done8  === 1'b1 && l8  == 0) l8  = cyc - 1;
            if (done32 === 1'b1 && l32 == 0) l32 = cyc - 1;
            if (done1  === 1'b1 && l1  == 0) l1  = cyc - 1;
            tick;
        end
        n_checks++; if (l8 !== 4) begin n_fail++; $display("FAIL sweep_c8_latency got %0d exp 4", l8); end
        n_checks++; if (l32 !== 1) begin n_fail++; $display("FAIL sweep_c32_latency got %0d exp 1", l32); end
        n_checks++; if (l1 !== 32) begin n_fail++; $display("FAIL sweep_c1_latency got %0d exp 32", l1); end
        n_checks++;
        if (r32 !== 32'h0 || c32 !== 1'b1 || o32 !== 1'b0) begin
            n_fail++; $display("FAIL sweep_c32_values got %h/%b/%b exp 00000000/1/0", r32, c32, o32);
        end
        n_checks++;
        if (r1 !== 32'h0 || c1 !== 1'b1 || o1 !== 1'b0) begin
            n_fail++; $display("FAIL sweep_c1_values got %h/%b/%b exp 00000000/1/0", r1, c1, o1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset;
        test_add_ripple;
        test_subtract;
        test_overflow;
        test_back_to_back;
        test_reset_mid_run;
        test_param_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
